// File: rtl/simd_regfile_wb.sv
// simd_regfile_wb
// Writeback-side register file for the SIMD pipeline: NREGS x DW storage,
// one writeback port, three asynchronous read ports and a handshaked dump
// engine that streams every register out in index order.
//
// Build option: define WB_BYPASS_EN to forward dataWB to any read port whose
// address matches rd while WE is high (same-cycle write-before-read).
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   WE, rd, dataWB            writeback enable / index / data
//   rsN_addr -> rsN_data      combinational read ports (N = 1..3)
//   dump_start                request a full dump (ignored while busy)
//   dump_ready                sink accepts the current beat
//   dump_valid, dump_addr,
//   dump_data                 current beat (registered, stable under stall)
//   dump_busy                 engine not idle
//   dump_done                 one-cycle pulse after the last beat is taken
//
// Dump FSM
//   state | meaning
//   IDLE  | no dump in progress, waiting for dump_start
//   SEND  | presenting beat dump_addr, advancing on dump_valid & dump_ready

module simd_regfile_wb #(
    parameter int NREGS = 32,
    parameter int DW    = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WE,
    input  logic [4:0]    rd,
    input  logic [DW-1:0] dataWB,
    input  logic [4:0]    rs1_addr,
    input  logic [4:0]    rs2_addr,
    input  logic [4:0]    rs3_addr,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rs2_data,
    output logic [DW-1:0] rs3_data,
    input  logic          dump_start,
    input  logic          dump_ready,
    output logic          dump_valid,
    output logic [4:0]    dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          dump_busy,
    output logic          dump_done
);

    typedef enum logic {IDLE, SEND} dump_state_t;

    logic [DW-1:0] regs [NREGS];

    dump_state_t   state, state_nxt;
    logic [4:0]    addr_nxt;
    logic [DW-1:0] data_nxt;
    logic          done_nxt;
    logic [4:0]    load_idx;
    logic [DW-1:0] load_data;

    // Register storage. Every entry is writable, including index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WE) begin
            regs[rd] <= dataWB;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs1_data = (WE && rs1_addr == rd) ? dataWB : regs[rs1_addr];
    assign rs2_data = (WE && rs2_addr == rd) ? dataWB : regs[rs2_addr];
    assign rs3_data = (WE && rs3_addr == rd) ? dataWB : regs[rs3_addr];
`else
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];
    assign rs3_data = regs[rs3_addr];
`endif

    // Index of the beat that would be loaded on this edge. A writeback to the
    // same index in the same cycle is captured so the beat is never stale.
    assign load_idx  = (state == IDLE) ? 5'd0 : dump_addr + 5'd1;
    assign load_data = (WE && rd == load_idx) ? dataWB : regs[load_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dump_addr <= '0;
            dump_data <= '0;
            dump_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            dump_addr <= addr_nxt;
            dump_data <= data_nxt;
            dump_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = dump_addr;
        data_nxt  = dump_data;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt = SEND;
                    addr_nxt  = 5'd0;
                    data_nxt  = load_data;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (dump_addr == 5'(NREGS - 1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        addr_nxt = load_idx;
                        data_nxt = load_data;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dump_valid = (state == SEND);
    assign dump_busy  = (state == SEND);

endmodule

// File: tb/tb_simd_regfile_wb.sv
// Directed testbench for simd_regfile_wb. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns later, well clear of the next edge.

module tb_simd_regfile_wb;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         WE = 1'b0;
    logic [4:0]   rd = '0;
    logic [127:0] dataWB = '0;
    logic [4:0]   rs1_addr = '0, rs2_addr = '0, rs3_addr = '0;
    logic [127:0] rs1_data, rs2_data, rs3_data;
    logic         dump_start = 1'b0, dump_ready = 1'b0;
    logic         dump_valid, dump_busy, dump_done;
    logic [4:0]   dump_addr;
    logic [127:0] dump_data;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] K_WR = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;

    simd_regfile_wb #(.NREGS(32), .DW(128)) dut (
        .clk(clk), .rst(rst), .WE(WE), .rd(rd), .dataWB(dataWB),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int beats;
    int done_cnt;

    initial begin
        // Reset asserted mid-cycle.
        #7 rst = 1'b1;
        #1;
        chk("rst_valid", dump_valid, 0);
        chk("rst_busy", dump_busy, 0);
        chk("rst_done", dump_done, 0);
        chk("rst_addr", dump_addr, 0);
        chk("rst_data", dump_data, 0);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            rs3_addr = 5'(31 - i);
            #1;
            chk("rst_read", rs1_data | rs2_data | rs3_data, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Write then read on all three ports.
        WE = 1'b1; rd = 5'd5; dataWB = K_WR;
        tick();
        WE = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd5; rs3_addr = 5'd5;
        #1;
        chk("wr_rs1", rs1_data, K_WR);
        chk("wr_rs2", rs2_data, K_WR);
        chk("wr_rs3", rs3_data, K_WR);
        rs1_addr = 5'd6;
        #1;
        chk("wr_rs1_other", rs1_data, 0);

        // Same-cycle read of the writeback index.
        tick();
        WE = 1'b1; rd = 5'd7; dataWB = 128'h1; rs2_addr = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_same", rs2_data, 128'h1);
`else
        chk("byp_same", rs2_data, 128'h0);
`endif
        tick();
        WE = 1'b0;
        #1;
        chk("byp_next", rs2_data, 128'h1);

        // Preload regs[i] = i.
        for (int i = 0; i < 32; i++) begin
            WE = 1'b1; rd = 5'(i); dataWB = 128'(i);
            tick();
        end
        WE = 1'b0;
        rs1_addr = 5'd5; rs3_addr = 5'd31;
        #1;
        chk("pre_r5", rs1_data, 5);
        chk("pre_r31", rs3_data, 31);

        // Dump with dump_ready toggling, stray dump_start mid-dump.
        dump_start = 1'b1; dump_ready = 1'b0;
        tick();
        dump_start = 1'b0;
        beats = 0;
        done_cnt = 0;
        for (int c = 0; c < 200 && beats < 32; c++) begin
            dump_ready = c[0];
            dump_start = (c == 21);
            #1;
            chk("dmp_valid", dump_valid, 1);
            chk("dmp_addr", dump_addr, 128'(beats));
            chk("dmp_data", dump_data, 128'(beats));
            if (dump_done) done_cnt++;
            if (dump_ready) beats++;
            tick();
        end
        dump_ready = 1'b0;
        dump_start = 1'b1;
        #1;
        chk("dmp_beats", 128'(beats), 32);
        chk("dmp_early_done", 128'(done_cnt), 0);
        chk("dmp_done", dump_done, 1);
        chk("dmp_end_valid", dump_valid, 0);
        chk("dmp_end_busy", dump_busy, 0);

        // Restart accepted in the dump_done cycle.
        tick();
        dump_start = 1'b0;
        #1;
        chk("rst2_done_pulse", dump_done, 0);
        chk("rst2_valid", dump_valid, 1);
        chk("rst2_addr", dump_addr, 0);

        // Stall at beat 3 and rewrite regs 3 and 4.
        dump_ready = 1'b1;
        tick(); tick(); tick();
        dump_ready = 1'b0;
        #1;
        chk("cw_addr3", dump_addr, 3);
        chk("cw_data3", dump_data, 3);
        WE = 1'b1; rd = 5'd3; dataWB = 128'hAA;
        tick();
        rd = 5'd4; dataWB = 128'hBB;
        tick();
        WE = 1'b0;
        #1;
        chk("cw_hold_addr", dump_addr, 3);
        chk("cw_hold_data", dump_data, 3);
        dump_ready = 1'b1;
        tick();
        dump_ready = 1'b0;
        #1;
        chk("cw_addr4", dump_addr, 4);
        chk("cw_data4", dump_data, 128'hBB);
        // Load of beat 5 coincides with a write to index 5.
        dump_ready = 1'b1; WE = 1'b1; rd = 5'd5; dataWB = 128'hCC;
        tick();
        WE = 1'b0; dump_ready = 1'b0;
        #1;
        chk("cw_addr5", dump_addr, 5);
        chk("cw_data5", dump_data, 128'hCC);

        // Advance to beat 10, then reset mid-cycle.
        dump_ready = 1'b1;
        for (int c = 0; c < 40 && dump_addr != 5'd10; c++) begin
            tick();
        end
        dump_ready = 1'b0;
        chk("mr_reach10", dump_addr, 10);
        #2 rst = 1'b1;
        #1;
        chk("mr_valid", dump_valid, 0);
        chk("mr_busy", dump_busy, 0);
        chk("mr_addr", dump_addr, 0);
        rs1_addr = 5'd3; rs2_addr = 5'd4; rs3_addr = 5'd10;
        #1;
        chk("mr_r3", rs1_data, 0);
        chk("mr_r4", rs2_data, 0);
        chk("mr_r10", rs3_data, 0);
        WE = 1'b1; rd = 5'd9; dataWB = 128'hFF;
        tick();
        WE = 1'b0;
        rst = 1'b0;
        rs1_addr = 5'd9;
        #1;
        chk("mr_wr_dropped", rs1_data, 0);
        tick();
        dump_start = 1'b1; dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        #1;
        chk("mr_restart_valid", dump_valid, 1);
        chk("mr_restart_addr", dump_addr, 0);
        tick();
        chk("mr_restart_addr1", dump_addr, 1);
        chk("mr_restart_data1", dump_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
